// File: rtl/jmp_if.sv
// jmp_if: jump-unit request/result bundle; master drives the decoded instruction, slave returns the decision.
//  start/op/field/regs/pc/target/ci_lt/ci_eq/ci_gt/ovf : request (master -> slave)
//  done/taken/next_pc/ovf_clr/illegal/rj                 : result  (slave -> master)
interface jmp_if #(parameter int W = 30, parameter int AW = 12, parameter int NREG = 8);
  logic                   start;
  logic [5:0]             op;
  logic [3:0]             field;
  logic [NREG*(W+1)-1:0]  regs;
  logic [AW-1:0]          pc;
  logic [AW-1:0]          target;
  logic                   ci_lt;
  logic                   ci_eq;
  logic                   ci_gt;
  logic                   ovf;
  logic                   done;
  logic                   taken;
  logic [AW-1:0]          next_pc;
  logic                   ovf_clr;
  logic                   illegal;
  logic [AW-1:0]          rj;
  modport master (output start, op, field, regs, pc, target, ci_lt, ci_eq, ci_gt, ovf,
                  input done, taken, next_pc, ovf_clr, illegal, rj);
  modport slave  (input start, op, field, regs, pc, target, ci_lt, ci_eq, ci_gt, ovf,
                  output done, taken, next_pc, ovf_clr, illegal, rj);
endinterface

// File: rtl/jmp_unit.sv
// jmp_unit: MIX jump decision (op 39 and register jumps op 40+i), registered next PC and rJ.
//  clk, rst_n : clock, asynchronous active-low reset
//  j (slave)  : request start/op/field/regs/pc/target/ci_*/ovf; result done/taken/next_pc/ovf_clr/illegal/rj
module jmp_unit #(parameter int W = 30, parameter int AW = 12, parameter int NREG = 8) (
  input logic clk,
  input logic rst_n,
  jmp_if.slave j
);
  logic [W:0]    r;
  logic          isreg, is39, z, s, c39, creg, ill, c, oc, jsj;
  logic [AW-1:0] pc1;
  always_comb begin
    r = '0;
    isreg = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (j.op == 6'(40 + i)) begin
        r = j.regs[i*(W+1) +: W+1];
        isreg = 1'b1;
      end
    // Zero test uses magnitude only, so minus zero counts as zero.
    z = ~|r[W-1:0];
    s = r[W];
    is39 = j.op == 6'd39;
    case (j.field)
      4'd0, 4'd1: c39 = 1'b1;
      4'd2:       c39 = j.ovf;
      4'd3:       c39 = ~j.ovf;
      4'd4:       c39 = j.ci_lt;
      4'd5:       c39 = j.ci_eq;
      4'd6:       c39 = j.ci_gt;
      4'd7:       c39 = j.ci_gt | j.ci_eq;
      4'd8:       c39 = ~j.ci_eq;
      4'd9:       c39 = j.ci_lt | j.ci_eq;
      default:    c39 = 1'b0;
    endcase
    case (j.field[2:0])
      3'd0:    creg = ~z & s;
      3'd1:    creg = z;
      3'd2:    creg = ~z & ~s;
      3'd3:    creg = z | ~s;
      3'd4:    creg = ~z;
      3'd5:    creg = z | s;
      3'd6:    creg = ~r[0];
      default: creg = r[0];
    endcase
    ill = ~((is39 & (j.field <= 4'd9)) | (isreg & ~j.field[3]));
    c = ~ill & (is39 ? c39 : creg);
    oc = is39 & (j.field == 4'd2 | j.field == 4'd3) & j.ovf;
    jsj = is39 & (j.field == 4'd1);
    pc1 = j.pc + AW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      j.done <= 1'b0;
      j.taken <= 1'b0;
      j.ovf_clr <= 1'b0;
      j.illegal <= 1'b0;
      j.next_pc <= '0;
      j.rj <= '0;
    end else begin
      j.done <= j.start;
      j.ovf_clr <= j.start & oc;
      if (j.start) begin
        j.taken <= c;
        j.illegal <= ill;
        j.next_pc <= c ? j.target : pc1;
        // JSJ jumps without saving the return address.
        if (c & ~jsj) j.rj <= pc1;
      end
    end
endmodule

// File: tb/tb_jmp_unit.sv
// tb_jmp_unit: directed self-checking bench for jmp_unit with a behavioural reference model.
module tb_jmp_unit;
  localparam int W = 30, AW = 12, NREG = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  jmp_if #(.W(W), .AW(AW), .NREG(NREG)) b();
  jmp_unit #(.W(W), .AW(AW), .NREG(NREG)) dut (.clk(clk), .rst_n(rst_n), .j(b));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  // Reference: {taken, illegal, ovf_clr} straight from the jump table.
  function automatic logic [2:0] judge(input logic [5:0] op, input logic [3:0] f,
      input logic [NREG*(W+1)-1:0] rg, input logic lt, input logic eq, input logic gt, input logic ov);
    logic [W:0] r;
    logic [7:0] tbl;
    logic pos, neg, zero;
    int k;
    k = int'(f);
    if (op == 6'd39) begin
      if (k > 9) return 3'b010;
      return {k <= 1 || (k == 2 && ov) || (k == 3 && !ov) || (k == 4 && lt) || (k == 5 && eq) ||
              (k == 6 && gt) || (k == 7 && (gt || eq)) || (k == 8 && !eq) || (k == 9 && (lt || eq)),
              1'b0, (k == 2 || k == 3) && ov};
    end
    if (int'(op) >= 40 && int'(op) < 40 + NREG) begin
      if (k > 7) return 3'b010;
      r = (W+1)'(rg >> ((int'(op) - 40) * (W + 1)));
      zero = r[W-1:0] == 0;
      pos = !zero && !r[W];
      neg = !zero && r[W];
      tbl = {r[0], !r[0], !pos, !zero, !neg, pos, zero, neg};
      return {tbl[k], 2'b00};
    end
    return 3'b010;
  endfunction
  logic [2:0] jv;
  assign jv = judge(b.op, b.field, b.regs, b.ci_lt, b.ci_eq, b.ci_gt, b.ovf);
  logic m_done, m_taken, m_ovf_clr, m_illegal;
  logic [AW-1:0] m_npc, m_rj;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_done <= 0; m_taken <= 0; m_ovf_clr <= 0; m_illegal <= 0; m_npc <= 0; m_rj <= 0;
    end else begin
      m_done <= b.start;
      m_ovf_clr <= b.start && jv[0];
      if (b.start) begin
        m_taken <= jv[2];
        m_illegal <= jv[1];
        m_npc <= jv[2] ? b.target : AW'(b.pc + 1);
        if (jv[2] && !(b.op == 6'd39 && b.field == 4'd1)) m_rj <= AW'(b.pc + 1);
      end
    end
  always @(negedge clk) begin
    chk("cmp_done", 32'(b.done), 32'(m_done));
    chk("cmp_taken", 32'(b.taken), 32'(m_taken));
    chk("cmp_illegal", 32'(b.illegal), 32'(m_illegal));
    chk("cmp_ovf_clr", 32'(b.ovf_clr), 32'(m_ovf_clr));
    chk("cmp_next_pc", 32'(b.next_pc), 32'(m_npc));
    chk("cmp_rj", 32'(b.rj), 32'(m_rj));
  end
  task automatic setreg(input int i, input logic s, input logic [W-1:0] mag);
    b.regs[i*(W+1) +: W+1] = {s, mag};
  endtask
  task automatic fire(input logic [5:0] op, input logic [3:0] f, input int pc, input int tgt);
    b.op = op; b.field = f; b.pc = AW'(pc); b.target = AW'(tgt); b.start = 1'b1;
    @(negedge clk);
  endtask
  task automatic idle();
    b.start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    b.regs = '0; b.ci_lt = 0; b.ci_eq = 0; b.ci_gt = 0; b.ovf = 0;
    b.op = 6'd39; b.field = 0; b.pc = 12'd7; b.target = 12'd9; b.start = 1'b1;
    // T1 reset with start held high
    repeat (2) @(negedge clk);
    chk("t1_rst_done", 32'(b.done), 0);
    chk("t1_rst_rj", 32'(b.rj), 0);
    chk("t1_rst_npc", 32'(b.next_pc), 0);
    b.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    fire(39, 0, 7, 9);
    chk("t1_done", 32'(b.done), 1);
    chk("t1_npc", 32'(b.next_pc), 9);
    idle();
    chk("t1_done_drop", 32'(b.done), 0);
    // T2 JMP / JSJ
    fire(39, 0, 100, 3000);
    chk("t2_jmp_taken", 32'(b.taken), 1);
    chk("t2_jmp_npc", 32'(b.next_pc), 3000);
    chk("t2_jmp_rj", 32'(b.rj), 101);
    fire(39, 1, 500, 200);
    chk("t2_jsj_npc", 32'(b.next_pc), 200);
    chk("t2_jsj_rj", 32'(b.rj), 101);
    idle();
    // T3 overflow
    b.ovf = 1;
    fire(39, 2, 20, 50);
    chk("t3_jov_taken", 32'(b.taken), 1);
    chk("t3_jov_clr", 32'(b.ovf_clr), 1);
    fire(39, 3, 10, 77);
    chk("t3_jnov1_taken", 32'(b.taken), 0);
    chk("t3_jnov1_npc", 32'(b.next_pc), 11);
    chk("t3_jnov1_clr", 32'(b.ovf_clr), 1);
    b.ovf = 0;
    fire(39, 3, 10, 77);
    chk("t3_jnov0_taken", 32'(b.taken), 1);
    chk("t3_jnov0_clr", 32'(b.ovf_clr), 0);
    idle();
    chk("t3_clr_drop", 32'(b.ovf_clr), 0);
    // T4 register jumps
    setreg(0, 1'b1, '0);
    setreg(7, 1'b0, W'(5));
    setreg(1, 1'b0, W'(3));
    fire(40, 1, 200, 1);
    chk("t4_jaz_m0", 32'(b.taken), 1);
    fire(47, 7, 300, 2);
    chk("t4_jxo", 32'(b.taken), 1);
    chk("t4_jxo_rj", 32'(b.rj), 301);
    fire(41, 0, 400, 3);
    chk("t4_j1n", 32'(b.taken), 0);
    fire(40, 8, 600, 4);
    chk("t4_ill", 32'(b.illegal), 1);
    chk("t4_ill_taken", 32'(b.taken), 0);
    chk("t4_ill_rj", 32'(b.rj), 301);
    idle();
    // T5 back-to-back
    b.ci_eq = 1;
    fire(39, 5, 1000, 2000);
    chk("t5_p1_done", 32'(b.done), 1);
    chk("t5_p1_taken", 32'(b.taken), 1);
    fire(39, 4, 1001, 2001);
    chk("t5_p2_done", 32'(b.done), 1);
    chk("t5_p2_taken", 32'(b.taken), 0);
    fire(55, 0, 1002, 5);
    chk("t5_p3_done", 32'(b.done), 1);
    chk("t5_p3_ill", 32'(b.illegal), 1);
    chk("t5_p3_npc", 32'(b.next_pc), 1003);
    idle();
    chk("t5_done_drop", 32'(b.done), 0);
    // T6 wrap and reset mid-operation
    b.ci_eq = 0; b.ci_gt = 1;
    fire(39, 4, 4095, 9);
    chk("t6_wrap_npc", 32'(b.next_pc), 0);
    fire(39, 0, 4095, 33);
    chk("t6_wrap_rj", 32'(b.rj), 0);
    fire(39, 0, 50, 60);
    chk("t6_pre_rj", 32'(b.rj), 51);
    b.op = 6'd39; b.field = 0; b.pc = 12'd70; b.target = 12'd80; b.start = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    b.start = 1'b0;
    @(negedge clk);
    chk("t6_rst_done", 32'(b.done), 0);
    chk("t6_rst_rj", 32'(b.rj), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_done", 32'(b.done), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
